// File: rtl/addsub_iter_n_if.sv
// Handshake and result bundle for the iterative adder/subtractor.
// Valid/ready contract: start_i is a request that is accepted only on a
// rising edge where the block is idle (busy_o=0 and done_o=0). There is no
// back-pressure and no queuing. Results on sum_o/ovf_o/iter_o become valid
// with the one-cycle done_o pulse and are held until the next accepted start.
// state_o exposes the controller state for observation only.
interface addsub_iter_n_if #(
    parameter int N      = 8,
    parameter int ITER_W = $clog2(N + 2)
) ();
    logic              start_i;
    logic              sub_i;
    logic [N-1:0]      data0_i;
    logic [N-1:0]      data1_i;
    logic              busy_o;
    logic              done_o;
    logic [N:0]        sum_o;
    logic              ovf_o;
    logic [ITER_W-1:0] iter_o;
    logic [1:0]        state_o;

    modport master (
        output start_i, sub_i, data0_i, data1_i,
        input  busy_o, done_o, sum_o, ovf_o, iter_o, state_o
    );

    modport slave (
        input  start_i, sub_i, data0_i, data1_i,
        output busy_o, done_o, sum_o, ovf_o, iter_o, state_o
    );
endinterface

// File: rtl/addsub_iter_n.sv
// Iterative carry-resolving adder/subtractor. An operand register A and a
// carry register B are folded through one bank of full adders per ITER
// cycle until no carry remains; subtraction is A + ~B + 1 with the +1
// injected as the carry-in of the first ITER cycle only.
module addsub_iter_n #(
    parameter int N      = 8,
    parameter int ITER_W = $clog2(N + 2)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    addsub_iter_n_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [N:0]        r_a;
    logic [N:0]        r_b;
    logic              r_cin;
    logic              r_a_msb;
    logic              r_b_msb;
    logic              r_sub;
    logic [ITER_W-1:0] r_cnt;
    logic [N:0]        r_sum;
    logic              r_ovf;
    logic [ITER_W-1:0] r_iter;

    logic [N:0]        w_c;
    logic [N:0]        w_a_next;
    logic [N:0]        w_maj;
    logic [N:0]        w_b_next;
    logic [ITER_W-1:0] w_cnt_next;
    logic              w_ovf;
    logic              w_busy;
    logic              w_done;

    // One full-adder bank step; the carry-in only exists on the first step.
    always_comb begin
        w_c        = {{N{1'b0}}, r_cin};
        w_a_next   = r_a ^ r_b ^ w_c;
        w_maj      = (r_a & r_b) | (r_a & w_c) | (r_b & w_c);
        w_b_next   = w_maj << 1;
        w_cnt_next = r_cnt + ITER_W'(1);
        // Latched b is the raw data1 MSB, so sub overflow needs differing signs.
        if (r_sub) begin
            w_ovf = (r_a_msb != r_b_msb) && (w_a_next[N-1] != r_a_msb);
        end else begin
            w_ovf = (r_a_msb == r_b_msb) && (w_a_next[N-1] != r_a_msb);
        end
    end

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode; outputs depend on state only.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_state_next = S_ITER;
            end
            S_ITER: begin
                w_busy = 1'b1;
                if (w_b_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_a     <= {1'b0, bus.data0_i};
                        r_b     <= {1'b0, (bus.sub_i ? ~bus.data1_i : bus.data1_i)};
                        r_cin   <= bus.sub_i;
                        r_a_msb <= bus.data0_i[N-1];
                        r_b_msb <= bus.data1_i[N-1];
                        r_sub   <= bus.sub_i;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                end
                S_ITER: begin
                    r_a   <= w_a_next;
                    r_b   <= w_b_next;
                    r_cin <= 1'b0;
                    r_cnt <= w_cnt_next;
                    if (w_b_next == '0) begin
                        r_sum  <= w_a_next;
                        r_iter <= w_cnt_next;
                        r_ovf  <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy_o  = w_busy;
    assign bus.done_o  = w_done;
    assign bus.sum_o   = r_sum;
    assign bus.ovf_o   = r_ovf;
    assign bus.iter_o  = r_iter;
    assign bus.state_o = r_state;

endmodule
